// File: rtl/ftoi_pipe.sv
// Pipelined float-to-signed-integer converter: unpack/classify, align, then round/saturate.
// Four rounding modes, two's-complement saturation, invalid/inexact flags.
module ftoi_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_x,
  input  logic [1:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       out_y,
  output logic                   out_invalid,
  output logic                   out_inexact
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int UW   = EXP_W + 1;
  localparam int WW   = (MAN_W > INT_W) ? MAN_W + 1 : INT_W + 1;

  localparam logic [INT_W-1:0] Y_MAX       = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] Y_MIN       = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   MAG_MAX_POS = {1'b0, Y_MAX};
  localparam logic [INT_W:0]   MAG_MAX_NEG = {1'b0, Y_MIN};

  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} cls_t;

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole
  // pipe advances together when the output slot is free or being consumed.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: unpack and classify
  logic             x_s;
  logic [EXP_W-1:0] x_e;
  logic [MAN_W-1:0] x_m;
  logic signed [UW-1:0] x_u;
  cls_t             x_cls;

  assign x_s = in_x[EXP_W+MAN_W];
  assign x_e = in_x[EXP_W+MAN_W-1:MAN_W];
  assign x_m = in_x[MAN_W-1:0];
  assign x_u = $signed({1'b0, x_e}) - $signed(UW'(BIAS));

  always_comb begin
    x_cls = CL_NORM;
    if (x_e == '0)      x_cls = CL_ZERO;
    else if (x_e == '1) x_cls = (x_m == '0) ? CL_INF : CL_NAN;
  end

  logic                 s1_valid, s1_sign;
  logic signed [UW-1:0] s1_u;
  logic [MAN_W:0]       s1_sig;
  logic [1:0]           s1_rm;
  cls_t                 s1_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_u     <= '0;
      s1_sig   <= '0;
      s1_rm    <= '0;
      s1_cls   <= CL_ZERO;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_sign  <= x_s;
      s1_u     <= x_u;
      s1_sig   <= {1'b1, x_m};
      s1_rm    <= in_rm;
      s1_cls   <= x_cls;
    end
  end

  // S2: align the significand to the integer point, keeping guard and sticky
  int                 u_i;
  logic [2*MAN_W+1:0] rsh;
  logic [WW-1:0]      mag_w;
  logic               guard_c, sticky_c, pre_ovf_c;

  always_comb begin
    u_i       = int'(s1_u);
    rsh       = {s1_sig, {(MAN_W+1){1'b0}}} >> (MAN_W - u_i);
    mag_w     = '0;
    guard_c   = 1'b0;
    sticky_c  = 1'b0;
    pre_ovf_c = (u_i >= INT_W);
    if (u_i < 0) begin
      guard_c  = (u_i == -1);
      sticky_c = (u_i < -1) || (s1_sig[MAN_W-1:0] != '0);
    end else if (u_i <= MAN_W) begin
      mag_w    = WW'(rsh[2*MAN_W+1:MAN_W+1]);
      guard_c  = rsh[MAN_W];
      sticky_c = |rsh[MAN_W-1:0];
    end else begin
      mag_w = WW'(s1_sig) << (u_i - MAN_W);
    end
  end

  logic           s2_valid, s2_sign, s2_guard, s2_sticky, s2_pre_ovf;
  logic [INT_W:0] s2_mag;
  logic [1:0]     s2_rm;
  cls_t           s2_cls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_guard   <= 1'b0;
      s2_sticky  <= 1'b0;
      s2_pre_ovf <= 1'b0;
      s2_mag     <= '0;
      s2_rm      <= '0;
      s2_cls     <= CL_ZERO;
    end else if (adv) begin
      s2_valid   <= s1_valid;
      s2_sign    <= s1_sign;
      s2_guard   <= guard_c;
      s2_sticky  <= sticky_c;
      s2_pre_ovf <= pre_ovf_c;
      s2_mag     <= mag_w[INT_W:0];
      s2_rm      <= s1_rm;
      s2_cls     <= s1_cls;
    end
  end

  // S3: round the magnitude, apply sign, saturate out-of-range and special inputs
  logic             inc, ovf, inv_c, inx_c;
  logic [INT_W:0]   rnd;
  logic [INT_W-1:0] y_c;

  always_comb begin
    inc = 1'b0;
    case (s2_rm)
      2'b00:   inc = 1'b0;
      2'b01:   inc = s2_guard;
      2'b10:   inc = s2_guard && (s2_sticky || s2_mag[0]);
      default: inc = s2_sign && (s2_guard || s2_sticky);
    endcase
    rnd   = s2_mag + {{INT_W{1'b0}}, inc};
    ovf   = s2_pre_ovf || (s2_sign ? (rnd > MAG_MAX_NEG) : (rnd > MAG_MAX_POS));
    y_c   = '0;
    inv_c = 1'b0;
    inx_c = 1'b0;
    case (s2_cls)
      CL_NAN: begin
        y_c   = Y_MAX;
        inv_c = 1'b1;
      end
      CL_INF: begin
        y_c   = s2_sign ? Y_MIN : Y_MAX;
        inv_c = 1'b1;
      end
      CL_NORM: begin
        if (ovf) begin
          y_c   = s2_sign ? Y_MIN : Y_MAX;
          inv_c = 1'b1;
        end else begin
          y_c   = s2_sign ? -rnd[INT_W-1:0] : rnd[INT_W-1:0];
          inx_c = s2_guard || s2_sticky;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_invalid <= 1'b0;
      out_inexact <= 1'b0;
    end else if (adv) begin
      out_valid   <= s2_valid;
      out_y       <= y_c;
      out_invalid <= inv_c;
      out_inexact <= inx_c;
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: single precision instance with scoreboard and random back-pressure,
// plus a half precision instance for the reduced parameter set.
module tb_ftoi_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // single precision DUT
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x = '0;
  logic [1:0]  in_rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_y;
  logic        out_invalid, out_inexact;

  ftoi_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  // half precision DUT
  logic        h_in_valid = 1'b0;
  logic        h_in_ready;
  logic [15:0] h_in_x = '0;
  logic [1:0]  h_in_rm = '0;
  logic        h_out_valid;
  logic        h_out_ready = 1'b1;
  logic [15:0] h_out_y;
  logic        h_out_invalid, h_out_inexact;

  ftoi_pipe #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(h_in_valid), .in_ready(h_in_ready), .in_x(h_in_x), .in_rm(h_in_rm),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_y(h_out_y),
    .out_invalid(h_out_invalid), .out_inexact(h_out_inexact)
  );

  // ---------------- vectors: operand, mode, {y, invalid, inexact} ----------------
  localparam int NV = 25;
  localparam logic [31:0] VX [NV] = '{
    32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h40200000, 32'h40200000,
    32'hBFC00000, 32'hBFC00000, 32'hBE99999A, 32'h3E99999A, 32'h4F000000,
    32'hCF000000, 32'h7FC00000, 32'hFF800000, 32'h00000001, 32'h42F60000,
    32'h3F000000, 32'h3F000000, 32'hBF000000, 32'h4EFFFFFF, 32'hCF000001,
    32'h40600000, 32'h7F800000, 32'h80000000, 32'h3F800000, 32'h80000001};
  localparam logic [1:0] VRM [NV] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd1,
    2'd3, 2'd0, 2'd3, 2'd1, 2'd0,
    2'd0, 2'd0, 2'd0, 2'd3, 2'd2,
    2'd2, 2'd1, 2'd3, 2'd0, 2'd1,
    2'd2, 2'd0, 2'd3, 2'd3, 2'd3};
  localparam logic [33:0] VE [NV] = '{
    {32'h00000001, 2'b01}, {32'h00000002, 2'b01}, {32'h00000002, 2'b01},
    {32'h00000002, 2'b01}, {32'h00000003, 2'b01}, {32'hFFFFFFFE, 2'b01},
    {32'hFFFFFFFF, 2'b01}, {32'hFFFFFFFF, 2'b01}, {32'h00000000, 2'b01},
    {32'h7FFFFFFF, 2'b10}, {32'h80000000, 2'b00}, {32'h7FFFFFFF, 2'b10},
    {32'h80000000, 2'b10}, {32'h00000000, 2'b00}, {32'h0000007B, 2'b00},
    {32'h00000000, 2'b01}, {32'h00000001, 2'b01}, {32'hFFFFFFFF, 2'b01},
    {32'h7FFFFF80, 2'b00}, {32'h80000000, 2'b10}, {32'h00000004, 2'b01},
    {32'h7FFFFFFF, 2'b10}, {32'h00000000, 2'b00}, {32'h00000001, 2'b00},
    {32'h00000000, 2'b00}};

  localparam int NH = 5;
  localparam logic [15:0] HX [NH]  = '{16'h7BFF, 16'h3E00, 16'hF800, 16'h3C00, 16'h7C00};
  localparam logic [1:0]  HRM [NH] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
  localparam logic [17:0] HE [NH]  = '{
    {16'h7FFF, 2'b10}, {16'h0002, 2'b01}, {16'h8000, 2'b00}, {16'h0001, 2'b00},
    {16'h7FFF, 2'b10}};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];
  logic [17:0] exp_h_q[$];
  bit rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [33:0] prev_out = '0;
  bit          prev_stall = 1'b0;
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_hold", 64'({out_y, out_invalid, out_inexact}), 64'(prev_out));
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL spurious_output: observed y=%h with nothing expected", out_y);
        end
        if (exp_q.size() != 0)
          check("result", 64'({out_y, out_invalid, out_inexact}), 64'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_y, out_invalid, out_inexact};
    end
  end

  always begin
    @(negedge clk);
    #3;
    if (!rst && h_out_valid) begin
      checks++;
      assert (exp_h_q.size() != 0) else begin
        errors++;
        $error("FAIL spurious_half: observed y=%h with nothing expected", h_out_y);
      end
      if (exp_h_q.size() != 0)
        check("half_result", 64'({h_out_y, h_out_invalid, h_out_inexact}), 64'(exp_h_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] x, input logic [1:0] rm, input logic [33:0] e,
                      input bit push);
    int n;
    @(negedge clk);
    #2;
    in_valid = 1'b1;
    in_x     = x;
    in_rm    = rm;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    assert (in_ready) else begin
      errors++;
      $error("FAIL accept_timeout: observed in_ready=%b expected 1", in_ready);
    end
    if (push && in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_h(input logic [15:0] x, input logic [1:0] rm, input logic [17:0] e);
    @(negedge clk);
    #2;
    h_in_valid = 1'b1;
    h_in_x     = x;
    h_in_rm    = rm;
    check("half_ready", 64'(h_in_ready), 64'd1);
    exp_h_q.push_back(e);
    @(posedge clk);
    #1;
    h_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_h_q.size() != 0) && n < 200) begin
      @(negedge clk);
      #4;
      n++;
    end
    check("drain_left", 64'(exp_q.size() + exp_h_q.size()), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", 64'(out_y), 64'd0);
    check("rst_flags", 64'({out_invalid, out_inexact}), 64'd0);
    check("rst_half_valid", 64'(h_out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // every vector in order, consumer always ready
    for (int i = 0; i < NV; i++) send(VX[i], VRM[i], VE[i], 1'b1);
    drain();

    // back-to-back stream with random back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int k;
      k = $urandom_range(0, NV - 1);
      send(VX[k], VRM[k], VE[k], 1'b1);
    end
    rand_ready = 1'b0;
    drain();

    // reset with three items in flight
    repeat (2) @(negedge clk);
    send(VX[0], VRM[0], VE[0], 1'b0);
    send(VX[4], VRM[4], VE[4], 1'b0);
    send(VX[9], VRM[9], VE[9], 1'b0);
    check("inflight_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("async_drop_valid", 64'(out_valid), 64'd0);
    check("async_drop_y", 64'({out_y, out_invalid, out_inexact}), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      check("no_stale_valid", 64'(out_valid), 64'd0);
    end
    @(negedge clk);
    #2;
    in_valid = 1'b1;
    in_x     = VX[5];
    in_rm    = VRM[5];
    check("post_rst_ready", 64'(in_ready), 64'd1);
    exp_q.push_back(VE[5]);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      #2;
      check("latency_valid", 64'(out_valid), 64'(k == 3));
    end
    drain();

    // half precision parameter set
    for (int i = 0; i < NH; i++) send_h(HX[i], HRM[i], HE[i]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
